// File: rtl/mlp_result_sender.sv
// mlp_result_sender: return-path UART transmitter for the MLP core.
// Reads LEN result bytes from the shared result RAM and sends them to the
// host as one back-to-back 8N1 frame {SYNC, LEN, payload[LEN], CHK}, where
// CHK = (LEN + sum of payload bytes) mod 256.
//
// Handshake: start is a level request sampled only in IDLE; the cycle it is
// seen high in IDLE, base_addr/length are latched and the frame begins on
// the same edge (busy rises, tx drops for the SYNC start bit). The RAM read
// port is strobe/latency based, not valid/ready: ram_rd_en pulses for one
// cycle with ram_addr, and ram_data is valid during the following cycle.
module mlp_result_sender #(
    parameter int          CLK_DIV = 434,
    parameter int          ADDR_W  = 15,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        length,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [7:0]        ram_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Frame sequencing
    state_t            state_q,     state_d;
    // Serializer: baud counter, bit index (0 start, 1..8 data, 9 stop), byte
    logic [CNT_W-1:0]  baud_q,      baud_d;
    logic [3:0]        bit_q,       bit_d;
    logic [7:0]        shift_q,     shift_d;
    // Registered outputs
    logic              tx_q,        tx_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic              ram_rd_en_q, ram_rd_en_d;
    // Latched request and payload bookkeeping
    logic [7:0]        len_q,       len_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [7:0]        loaded_q,    loaded_d;
    logic [7:0]        chk_q,       chk_d;
    // Prefetch: capture strobe delayed by the RAM latency, plus holding reg
    logic              rd_pend_q,   rd_pend_d;
    logic [7:0]        hold_q,      hold_d;

    // Set when the current byte's stop bit has just finished its last cycle
    logic              byte_end;
    logic              bit_end;
    logic              more_reads;

    // Bit timing: a bit ends when the baud counter wraps; a byte ends on the stop bit wrap
    always_comb begin
        bit_end  = (baud_q == CNT_MAX);
        byte_end = bit_end && (bit_q == 4'd9);
    end

    // After loading payload byte loaded_q+1, is there still a byte left to fetch?
    always_comb begin
        more_reads = ({1'b0, loaded_q} + 9'd1) < {1'b0, len_q};
    end

    // Next-state logic for the frame FSM, serializer and prefetch path
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_rd_en_d = 1'b0;
        len_d       = len_q;
        next_addr_d = next_addr_q;
        loaded_d    = loaded_q;
        chk_d       = chk_q;
        rd_pend_d   = ram_rd_en_q;
        hold_d      = hold_q;

        // Read data arrives the cycle after the strobe; park it until needed
        if (rd_pend_q) begin
            hold_d = ram_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SYNC;
                    busy_d      = 1'b1;
                    tx_d        = 1'b0;
                    baud_d      = '0;
                    bit_d       = 4'd0;
                    shift_d     = SYNC;
                    len_d       = length;
                    chk_d       = length;
                    next_addr_d = base_addr;
                    loaded_d    = 8'd0;
                end
            end

            ST_SYNC, ST_LEN, ST_PAYLOAD, ST_CHK: begin
                if (!bit_end) begin
                    baud_d = baud_q + CNT_W'(1);
                end else begin
                    baud_d = '0;
                    if (!byte_end) begin
                        // Next bit: data bit bit_q (LSB first) or the stop bit
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : shift_q[bit_q[2:0]];
                    end else begin
                        // Byte finished: start the next one with no idle gap
                        bit_d = 4'd0;
                        tx_d  = 1'b0;
                        if (state_q == ST_SYNC) begin
                            state_d = ST_LEN;
                            shift_d = len_q;
                            if (len_q != 8'd0) begin
                                ram_rd_en_d = 1'b1;
                                ram_addr_d  = next_addr_q;
                                next_addr_d = next_addr_q + 1'b1;
                            end
                        end else if (state_q == ST_CHK) begin
                            state_d = ST_DONE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if ((state_q == ST_LEN && len_q == 8'd0) ||
                                     (state_q == ST_PAYLOAD && loaded_q == len_q)) begin
                            // All payload sent (or none): checksum is complete
                            state_d = ST_CHK;
                            shift_d = chk_q;
                        end else begin
                            // Move the prefetched byte into the shifter, fetch the next
                            state_d  = ST_PAYLOAD;
                            shift_d  = hold_q;
                            chk_d    = chk_q + hold_q;
                            loaded_d = loaded_q + 8'd1;
                            if (more_reads) begin
                                ram_rd_en_d = 1'b1;
                                ram_addr_d  = next_addr_q;
                                next_addr_d = next_addr_q + 1'b1;
                            end
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset abandons any frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_q       <= 4'd0;
            shift_q     <= 8'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_rd_en_q <= 1'b0;
            len_q       <= 8'd0;
            next_addr_q <= '0;
            loaded_q    <= 8'd0;
            chk_q       <= 8'd0;
            rd_pend_q   <= 1'b0;
            hold_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_addr_q  <= ram_addr_d;
            ram_rd_en_q <= ram_rd_en_d;
            len_q       <= len_d;
            next_addr_q <= next_addr_d;
            loaded_q    <= loaded_d;
            chk_q       <= chk_d;
            rd_pend_q   <= rd_pend_d;
            hold_q      <= hold_d;
        end
    end

    // All outputs come straight from flops
    always_comb begin
        tx        = tx_q;
        busy      = busy_q;
        done      = done_q;
        ram_addr  = ram_addr_q;
        ram_rd_en = ram_rd_en_q;
    end

endmodule

// File: tb/tb_mlp_result_sender.sv
// tb_mlp_result_sender: directed bench for mlp_result_sender with CLK_DIV=4.
// A UART monitor decodes tx into bytes; a RAM model with one-cycle read
// latency answers ram_rd_en; expected bytes, checksums, read addresses and
// frame durations are hand-computed per vector.
module tb_mlp_result_sender;

  localparam int CLK_DIV = 4;
  localparam int ADDR_W  = 15;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        length = 8'd0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [7:0]        ram_data;
  logic              tx;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mlp_result_sender #(
    .CLK_DIV (CLK_DIV),
    .ADDR_W  (ADDR_W),
    .SYNC    (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .ram_addr  (ram_addr),
    .ram_rd_en (ram_rd_en),
    .ram_data  (ram_data),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- RAM model ----------------
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_rd_en) ram_data <= mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]        exp_q[$];
  logic [7:0]        rx_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int rd_cnt   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- UART monitor (samples on falling edge) ----------------
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_sh = 8'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == 2) begin
          check("start_bit", {31'd0, tx}, 32'd0);
        end else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 2) % CLK_DIV) == 0) begin
          mon_sh = {tx, mon_sh[7:1]};
        end else if (mon_cnt == 38) begin
          check("stop_bit", {31'd0, tx}, 32'd1);
          rx_q.push_back(mon_sh);
          mon_active = 1'b0;
        end
      end
    end
  end

  // RAM strobe and done-pulse monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (ram_rd_en === 1'b1) begin
          rd_cnt++;
          addr_q.push_back(ram_addr);
        end
        if (done === 1'b1) done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    rx_q.delete();
    exp_addr_q.delete();
    addr_q.delete();
    rd_cnt = 0;
    done_cnt = 0;
  endtask

  // Sends one frame and checks bytes, reads, duration and done pulse.
  // inject=1 pulses start and changes base/length at cycle 50 of the frame.
  task automatic run_frame(input string tag, input logic [ADDR_W-1:0] base,
                           input logic [7:0] len, input logic [7:0] exp_chk,
                           input int inject);
    int t0;
    int dur;
    bit finished;
    logic [ADDR_W-1:0] a;
    clear_sb();
    exp_q.push_back(8'hA5);
    exp_q.push_back(len);
    for (int i = 0; i < int'(len); i++) begin
      a = base + ADDR_W'(i);
      exp_q.push_back(mem[a]);
      exp_addr_q.push_back(a);
    end
    exp_q.push_back(exp_chk);

    base_addr = base;
    length    = len;
    start     = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    check({tag, "_tx_start"}, {31'd0, tx}, 32'd0);
    finished = 1'b0;
    dur = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (inject == 1 && cyc == t0 + 50) begin
        start     = 1'b1;
        base_addr = 15'h0200;
        length    = 8'd7;
      end
      if (inject == 1 && cyc == t0 + 51) start = 1'b0;
      if (done === 1'b1) begin
        finished = 1'b1;
        dur = cyc - t0;
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        break;
      end
    end
    if (!finished) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    check({tag, "_duration"}, dur, (int'(len) + 3) * 10 * CLK_DIV);
    start = 1'b0;
    repeat (4) tick();
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);

    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q.pop_front()}, {24'd0, exp_q.pop_front()});
    check({tag, "_rd_pulses"}, rd_cnt, int'(len));
    for (int i = 0; exp_addr_q.size() > 0 && addr_q.size() > 0; i++)
      check($sformatf("%s_addr%0d", tag, i), {17'd0, addr_q.pop_front()}, {17'd0, exp_addr_q.pop_front()});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    bool_dummy: begin end
    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    check("rst_tx",   {31'd0, tx},        32'd1);
    check("rst_busy", {31'd0, busy},      32'd0);
    check("rst_done", {31'd0, done},      32'd0);
    check("rst_rden", {31'd0, ram_rd_en}, 32'd0);
    check("rst_addr", {17'd0, ram_addr},  32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // 1: three bytes; CHK = 03+10+20+30 = 0x63
    mem[15'h0100] = 8'h10;
    mem[15'h0101] = 8'h20;
    mem[15'h0102] = 8'h30;
    run_frame("s1", 15'h0100, 8'd3, 8'h63, 0);

    // 2: empty payload -> A5 00 00, no reads, 120 cycles
    run_frame("s2", 15'h0100, 8'd0, 8'h00, 0);

    // 3: checksum carry discarded: 02+FF+FF = 0x200 -> 0x00
    mem[15'h0010] = 8'hFF;
    mem[15'h0011] = 8'hFF;
    run_frame("s3", 15'h0010, 8'd2, 8'h00, 0);

    // 4: address wrap 7FFF -> 0000; CHK = 02+5A+C3 = 0x11F -> 0x1F
    mem[15'h7FFF] = 8'h5A;
    mem[15'h0000] = 8'hC3;
    run_frame("s4", 15'h7FFF, 8'd2, 8'h1F, 0);

    // 5: start pulse and input changes mid-frame are ignored
    run_frame("s5", 15'h0100, 8'd3, 8'h63, 1);

    // 6: reset during the LEN byte, then a clean frame
    base_addr = 15'h0100;
    length    = 8'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 200 && cyc < t0 + 50; i++) tick();
    check("s6_reached_len", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    check("s6_rst_tx",   {31'd0, tx},        32'd1);
    check("s6_rst_busy", {31'd0, busy},      32'd0);
    check("s6_rst_rden", {31'd0, ram_rd_en}, 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("s6_idle_tx", {31'd0, tx}, 32'd1);
    run_frame("s6", 15'h0100, 8'd3, 8'h63, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
